// File: rtl/ahbl_arbiter.sv
// AHB-lite N:1 round-robin arbiter with a per-port address-phase buffer,
// HMASTLOCK grant hold and exclusive-access passthrough.
module ahbl_arbiter #(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        src_hready,
  output logic [N_PORTS-1:0]        src_hready_resp,
  output logic [N_PORTS-1:0]        src_hresp,
  input  logic [N_PORTS*W_ADDR-1:0] src_haddr,
  input  logic [N_PORTS-1:0]        src_hwrite,
  input  logic [N_PORTS*2-1:0]      src_htrans,
  input  logic [N_PORTS*3-1:0]      src_hsize,
  input  logic [N_PORTS*3-1:0]      src_hburst,
  input  logic [N_PORTS*4-1:0]      src_hprot,
  input  logic [N_PORTS-1:0]        src_hmastlock,
  input  logic [N_PORTS-1:0]        src_hexcl,
  input  logic [N_PORTS*8-1:0]      src_hmaster,
  input  logic [N_PORTS*W_DATA-1:0] src_hwdata,
  output logic [N_PORTS*W_DATA-1:0] src_hrdata,
  output logic [N_PORTS-1:0]        src_hexokay,
  output logic                      dst_hready,
  input  logic                      dst_hready_resp,
  input  logic                      dst_hresp,
  output logic [W_ADDR-1:0]         dst_haddr,
  output logic                      dst_hwrite,
  output logic [1:0]                dst_htrans,
  output logic [2:0]                dst_hsize,
  output logic [2:0]                dst_hburst,
  output logic [3:0]                dst_hprot,
  output logic                      dst_hmastlock,
  output logic                      dst_hexcl,
  output logic [7:0]                dst_hmaster,
  output logic [W_DATA-1:0]         dst_hwdata,
  input  logic [W_DATA-1:0]         dst_hrdata,
  input  logic                      dst_hexokay
);

  localparam int         W_IDX       = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  typedef struct packed {
    logic [W_ADDR-1:0] addr;
    logic              write;
    logic [1:0]        trans;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [3:0]        prot;
    logic              lock;
    logic              excl;
    logic [7:0]        master;
  } req_t;

  req_t               live_req [N_PORTS];
  req_t               eff_req  [N_PORTS];
  req_t               buf_q    [N_PORTS];
  req_t               buf_d    [N_PORTS];
  req_t               sel_req;
  logic [N_PORTS-1:0] live, req, issue_oh;
  logic [N_PORTS-1:0] buf_valid_q, buf_valid_d;
  logic [N_PORTS-1:0] data_grant_q, data_grant_d;
  logic [W_IDX-1:0]   last_grant_q, last_grant_d, grant_idx;
  logic               lock_q, lock_d;
  logic               found, issue;

  function automatic logic [W_IDX-1:0] wrap_add(input logic [W_IDX-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_PORTS) s = s - N_PORTS;
    return W_IDX'(s);
  endfunction

  // A buffered port is stalled, so its live request and buffer never coexist.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      live_req[i] = '{addr:   src_haddr[i*W_ADDR +: W_ADDR],
                      write:  src_hwrite[i],
                      trans:  src_htrans[i*2 +: 2],
                      size:   src_hsize[i*3 +: 3],
                      burst:  src_hburst[i*3 +: 3],
                      prot:   src_hprot[i*4 +: 4],
                      lock:   src_hmastlock[i],
                      excl:   src_hexcl[i],
                      master: src_hmaster[i*8 +: 8]};
      live[i]    = src_hready[i] && (src_htrans[i*2 +: 2] != HTRANS_IDLE);
      req[i]     = buf_valid_q[i] | live[i];
      eff_req[i] = buf_valid_q[i] ? buf_q[i] : live_req[i];
    end
  end

  // Descending scan so the port closest after last_grant wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = last_grant_q;
    if (lock_q) begin
      found = req[last_grant_q];
    end else begin
      for (int k = N_PORTS; k >= 1; k--) begin
        if (req[wrap_add(last_grant_q, k)]) begin
          found     = 1'b1;
          grant_idx = wrap_add(last_grant_q, k);
        end
      end
    end
    issue    = found & dst_hready_resp;
    issue_oh = issue ? (N_PORTS'(1) << grant_idx) : '0;
    sel_req  = eff_req[grant_idx];
  end

  always_comb begin
    buf_valid_d  = buf_valid_q;
    buf_d        = buf_q;
    data_grant_d = data_grant_q;
    last_grant_d = last_grant_q;
    lock_d       = lock_q;
    for (int i = 0; i < N_PORTS; i++) begin
      if (live[i] && !issue_oh[i]) begin
        buf_valid_d[i] = 1'b1;
        buf_d[i]       = live_req[i];
      end else if (issue_oh[i]) begin
        buf_valid_d[i] = 1'b0;
      end
    end
    // An IDLE slot from the locked port drops the lock.
    if (dst_hready_resp) begin
      data_grant_d = issue_oh;
      lock_d       = issue & sel_req.lock;
      if (issue) last_grant_d = grant_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid_q  <= '0;
      data_grant_q <= '0;
      last_grant_q <= W_IDX'(N_PORTS - 1);
      lock_q       <= 1'b0;
      for (int i = 0; i < N_PORTS; i++) buf_q[i] <= '0;
    end else begin
      buf_valid_q  <= buf_valid_d;
      data_grant_q <= data_grant_d;
      last_grant_q <= last_grant_d;
      lock_q       <= lock_d;
      buf_q        <= buf_d;
    end
  end

  assign dst_hready    = dst_hready_resp;
  assign dst_htrans    = issue ? sel_req.trans : HTRANS_IDLE;
  assign dst_haddr     = sel_req.addr;
  assign dst_hwrite    = sel_req.write;
  assign dst_hsize     = sel_req.size;
  assign dst_hburst    = sel_req.burst;
  assign dst_hprot     = sel_req.prot;
  assign dst_hmastlock = sel_req.lock;
  assign dst_hexcl     = sel_req.excl;
  assign dst_hmaster   = sel_req.master;

  always_comb begin
    dst_hwdata = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (data_grant_q[i]) dst_hwdata = dst_hwdata | src_hwdata[i*W_DATA +: W_DATA];
    end
  end

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      if (data_grant_q[i]) src_hready_resp[i] = dst_hready_resp;
      else                 src_hready_resp[i] = !(buf_valid_q[i] | (live[i] & !issue_oh[i]));
    end
  end

  assign src_hresp   = data_grant_q & {N_PORTS{dst_hresp}};
  assign src_hexokay = data_grant_q & {N_PORTS{dst_hexokay}};
  assign src_hrdata  = {N_PORTS{dst_hrdata}};

endmodule

// File: tb/tb_ahbl_arbiter.sv
// Directed bench for ahbl_arbiter: stimulus pushes expected issues and
// data-phase responses into queues that an independent monitor consumes.
module tb_ahbl_arbiter;
  localparam int N = 2;
  localparam logic [1:0] IDLE = 2'b00, NSQ = 2'b10, SEQ = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    src_hready, src_hready_resp, src_hresp, src_hwrite, src_hmastlock, src_hexcl, src_hexokay;
  logic [N*32-1:0] src_haddr, src_hwdata, src_hrdata;
  logic [N*2-1:0]  src_htrans;
  logic [N*3-1:0]  src_hsize, src_hburst;
  logic [N*4-1:0]  src_hprot;
  logic [N*8-1:0]  src_hmaster;
  logic            dst_hready, dst_hready_resp, dst_hresp, dst_hwrite, dst_hmastlock, dst_hexcl, dst_hexokay;
  logic [31:0]     dst_haddr, dst_hwdata, dst_hrdata;
  logic [1:0]      dst_htrans;
  logic [2:0]      dst_hsize, dst_hburst;
  logic [3:0]      dst_hprot;
  logic [7:0]      dst_hmaster;

  ahbl_arbiter #(.N_PORTS(N), .W_ADDR(32), .W_DATA(32)) dut (
    .clk(clk), .rst(rst),
    .src_hready(src_hready), .src_hready_resp(src_hready_resp), .src_hresp(src_hresp),
    .src_haddr(src_haddr), .src_hwrite(src_hwrite), .src_htrans(src_htrans),
    .src_hsize(src_hsize), .src_hburst(src_hburst), .src_hprot(src_hprot),
    .src_hmastlock(src_hmastlock), .src_hexcl(src_hexcl), .src_hmaster(src_hmaster),
    .src_hwdata(src_hwdata), .src_hrdata(src_hrdata), .src_hexokay(src_hexokay),
    .dst_hready(dst_hready), .dst_hready_resp(dst_hready_resp), .dst_hresp(dst_hresp),
    .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite), .dst_htrans(dst_htrans),
    .dst_hsize(dst_hsize), .dst_hburst(dst_hburst), .dst_hprot(dst_hprot),
    .dst_hmastlock(dst_hmastlock), .dst_hexcl(dst_hexcl), .dst_hmaster(dst_hmaster),
    .dst_hwdata(dst_hwdata), .dst_hrdata(dst_hrdata), .dst_hexokay(dst_hexokay)
  );

  typedef struct { logic [31:0] addr; logic write; logic lock; logic [7:0] master; } aexp_t;
  typedef struct { int port; logic write; logic [31:0] data; logic resp; } dexp_t;

  aexp_t aq[$];
  dexp_t dq[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_a(input logic [31:0] a, input logic w, input logic l, input logic [7:0] m);
    aq.push_back('{addr: a, write: w, lock: l, master: m});
  endtask

  task automatic exp_d(input int p, input logic w, input logic [31:0] d, input logic r);
    dq.push_back('{port: p, write: w, data: d, resp: r});
  endtask

  task automatic drv(input int p, input logic [1:0] tr, input logic [31:0] a,
                     input logic wr, input logic lk, input logic rdy);
    src_htrans[p*2 +: 2]  = tr;
    src_haddr[p*32 +: 32] = a;
    src_hwrite[p]         = wr;
    src_hmastlock[p]      = lk;
    src_hready[p]         = rdy;
  endtask

  task automatic set_rdy(input int p, input logic v);
    src_hready[p] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: data phase tracked from the downstream bus itself.
  logic dp_valid = 1'b0;
  always @(negedge clk) begin : mon
    dexp_t d;
    aexp_t a;
    if (rst) begin
      dp_valid <= 1'b0;
    end else begin
      if (dp_valid && dst_hready_resp) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL data_unexpected: got completion on dst, expected none");
        end else begin
          d = dq.pop_front();
          check("dp_hready_resp", 64'(src_hready_resp[d.port]), 64'(1'b1));
          check("dp_hresp", 64'(src_hresp[d.port]), 64'(d.resp));
          if (!d.resp) begin
            if (d.write) check("dp_hwdata", 64'(dst_hwdata), 64'(d.data));
            else         check("dp_hrdata", 64'(src_hrdata[d.port*32 +: 32]), 64'(d.data));
          end
        end
      end
      if (dst_hready_resp && dst_htrans != IDLE) begin
        if (aq.size() == 0) begin
          checks++; errors++;
          $display("FAIL addr_unexpected: got issue at 0x%0h, expected none", dst_haddr);
        end else begin
          a = aq.pop_front();
          check("issue_addr", 64'(dst_haddr), 64'(a.addr));
          check("issue_write", 64'(dst_hwrite), 64'(a.write));
          check("issue_lock", 64'(dst_hmastlock), 64'(a.lock));
          check("issue_master", 64'(dst_hmaster), 64'(a.master));
        end
      end
      if (dst_hready_resp) dp_valid <= (dst_htrans != IDLE);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    src_hready = '1; src_htrans = '0; src_haddr = '0; src_hwrite = '0;
    src_hsize = {N{3'b010}}; src_hburst = '0; src_hprot = {N{4'b0011}};
    src_hmastlock = '0; src_hexcl = '0; src_hmaster = {8'd1, 8'd0}; src_hwdata = '0;
    dst_hready_resp = 1'b1; dst_hresp = 1'b0; dst_hrdata = '0; dst_hexokay = 1'b0;
    #3;
    check("rst_hready_resp", 64'(src_hready_resp), 64'(2'b11));
    check("rst_hresp", 64'(src_hresp), 64'(2'b00));
    check("rst_hexokay", 64'(src_hexokay), 64'(2'b00));
    check("rst_htrans", 64'(dst_htrans), 64'(IDLE));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // simultaneous pair after reset: port 0 first, port 1 buffered
    drv(0, NSQ, 32'h100, 0, 0, 1); drv(1, NSQ, 32'h200, 0, 0, 1);
    exp_a(32'h100, 0, 0, 8'd0); exp_d(0, 0, 32'hA0A0A0A0, 0);
    #1 check("pair_c1_ready", 64'(src_hready_resp), 64'(2'b01));
    tick();
    drv(0, NSQ, 32'h104, 0, 0, 1); set_rdy(1, 0); dst_hrdata = 32'hA0A0A0A0;
    exp_a(32'h200, 0, 0, 8'd1); exp_a(32'h104, 0, 0, 8'd0);
    exp_d(1, 0, 32'hB1B1B1B1, 0); exp_d(0, 0, 32'hC0C0C0C0, 0);
    #1 check("pair_c2_ready", 64'(src_hready_resp), 64'(2'b01));
    check("rr_port1_first", 64'(dst_haddr), 64'(32'h200));
    tick();
    set_rdy(0, 0); drv(1, IDLE, 0, 0, 0, 1); dst_hrdata = 32'hB1B1B1B1;
    #1 check("pair_c3_ready", 64'(src_hready_resp), 64'(2'b10));
    tick();
    drv(0, IDLE, 0, 0, 0, 1); dst_hrdata = 32'hC0C0C0C0;
    #1 check("pair_c4_ready", 64'(src_hready_resp), 64'(2'b11));
    tick();

    // port 0 alone, zero-wait read
    drv(0, NSQ, 32'h2000_0010, 0, 0, 1);
    exp_a(32'h2000_0010, 0, 0, 8'd0); exp_d(0, 0, 32'hDEADBEEF, 0);
    #1 check("single_htrans", 64'(dst_htrans), 64'(NSQ));
    tick();
    drv(0, IDLE, 0, 0, 0, 1); dst_hrdata = 32'hDEADBEEF; dst_hexokay = 1'b1;
    #1 check("single_rdata", 64'(src_hrdata[31:0]), 64'(32'hDEADBEEF));
    check("single_ready", 64'(src_hready_resp[0]), 64'(1'b1));
    check("exokay_route", 64'(src_hexokay), 64'(2'b01));
    tick();
    dst_hexokay = 1'b0;

    // port 1 write with 3 wait states, port 0 buffered meanwhile
    src_hwdata = {32'h12345678, 32'hFFFF0000};
    drv(1, NSQ, 32'h300, 1, 0, 1);
    exp_a(32'h300, 1, 0, 8'd1); exp_d(1, 1, 32'h12345678, 0);
    tick();
    drv(1, IDLE, 0, 0, 0, 0); drv(0, NSQ, 32'h400, 0, 0, 1); dst_hready_resp = 1'b0;
    exp_a(32'h400, 0, 0, 8'd0); exp_d(0, 0, 32'h55AA55AA, 0);
    for (int w = 0; w < 3; w++) begin
      #1 check("wait_ready1", 64'(src_hready_resp[1]), 64'(1'b0));
      check("wait_ready0", 64'(src_hready_resp[0]), 64'(1'b0));
      check("wait_hwdata", 64'(dst_hwdata), 64'(32'h12345678));
      check("wait_no_issue", 64'(dst_htrans), 64'(IDLE));
      tick();
      set_rdy(0, 0);
    end
    dst_hready_resp = 1'b1;
    #1 check("wait_done_ready1", 64'(src_hready_resp[1]), 64'(1'b1));
    check("buf0_issue", 64'(dst_haddr), 64'(32'h400));
    tick();
    drv(0, IDLE, 0, 0, 0, 1); drv(1, IDLE, 0, 0, 0, 1); dst_hrdata = 32'h55AA55AA;
    tick();

    // two-cycle ERROR to port 0, port 1 buffered during it
    drv(0, NSQ, 32'h500, 0, 0, 1);
    exp_a(32'h500, 0, 0, 8'd0); exp_d(0, 0, 32'h0, 1);
    tick();
    drv(0, IDLE, 0, 0, 0, 0); drv(1, NSQ, 32'h600, 0, 0, 1);
    dst_hready_resp = 1'b0; dst_hresp = 1'b1;
    exp_a(32'h600, 0, 0, 8'd1); exp_d(1, 0, 32'h66666666, 0);
    #1 check("err1_hresp", 64'(src_hresp), 64'(2'b01));
    check("err1_ready0", 64'(src_hready_resp[0]), 64'(1'b0));
    tick();
    set_rdy(1, 0); set_rdy(0, 1); dst_hready_resp = 1'b1;
    #1 check("err2_hresp", 64'(src_hresp), 64'(2'b01));
    check("err2_ready0", 64'(src_hready_resp[0]), 64'(1'b1));
    check("err_buf1_issue", 64'(dst_haddr), 64'(32'h600));
    tick();
    dst_hresp = 1'b0; dst_hrdata = 32'h66666666; drv(1, IDLE, 0, 0, 0, 1);
    #1 check("err_after_hresp", 64'(src_hresp), 64'(2'b00));
    tick();

    // three locked transfers from port 0 while port 1 waits
    drv(0, NSQ, 32'h700, 0, 1, 1); drv(1, NSQ, 32'h800, 0, 0, 1);
    exp_a(32'h700, 0, 1, 8'd0); exp_a(32'h704, 0, 1, 8'd0);
    exp_a(32'h708, 0, 1, 8'd0); exp_a(32'h800, 0, 0, 8'd1);
    exp_d(0, 0, 32'h70000000, 0); exp_d(0, 0, 32'h70000004, 0);
    exp_d(0, 0, 32'h70000008, 0); exp_d(1, 0, 32'h80000000, 0);
    tick();
    drv(0, SEQ, 32'h704, 0, 1, 1); set_rdy(1, 0); dst_hrdata = 32'h70000000;
    #1 check("lock_hold_2", 64'(dst_haddr), 64'(32'h704));
    tick();
    drv(0, SEQ, 32'h708, 0, 1, 1); dst_hrdata = 32'h70000004;
    #1 check("lock_hold_3", 64'(dst_haddr), 64'(32'h708));
    tick();
    drv(0, IDLE, 0, 0, 0, 1); dst_hrdata = 32'h70000008;
    #1 check("lock_idle_gap", 64'(dst_htrans), 64'(IDLE));
    check("lock_p1_stalled", 64'(src_hready_resp[1]), 64'(1'b0));
    tick();
    #1 check("lock_p1_granted", 64'(dst_haddr), 64'(32'h800));
    tick();
    drv(1, IDLE, 0, 0, 0, 1); dst_hrdata = 32'h80000000;
    tick();

    // async reset with port 1 buffered and downstream in a wait state
    drv(0, NSQ, 32'h900, 1, 0, 1); drv(1, NSQ, 32'hA00, 0, 0, 1);
    exp_a(32'h900, 1, 0, 8'd0);
    tick();
    drv(0, IDLE, 0, 0, 0, 0); set_rdy(1, 0); dst_hready_resp = 1'b0;
    #1 check("prereset_ready", 64'(src_hready_resp), 64'(2'b00));
    #1 rst = 1'b1;
    #1 check("arst_hready_resp", 64'(src_hready_resp), 64'(2'b11));
    check("arst_hresp", 64'(src_hresp), 64'(2'b00));
    check("arst_hexokay", 64'(src_hexokay), 64'(2'b00));
    check("arst_htrans", 64'(dst_htrans), 64'(IDLE));
    tick();
    dst_hready_resp = 1'b1; set_rdy(0, 1); rst = 1'b0;
    drv(1, NSQ, 32'hB00, 0, 0, 1);
    exp_a(32'hB00, 0, 0, 8'd1); exp_d(1, 0, 32'hBBBB0000, 0);
    #1 check("post_reset_issue", 64'(dst_htrans), 64'(NSQ));
    tick();
    drv(1, IDLE, 0, 0, 0, 1); dst_hrdata = 32'hBBBB0000;
    repeat (2) tick();

    check("addr_queue_empty", 64'(aq.size()), 64'(0));
    check("data_queue_empty", 64'(dq.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
